// File: rtl/sdram_init_ref_seq_pkg.sv
// Shared types and constants for the SDRAM init/refresh command sequencer.
//   state_t : sequencer FSM states (init path I_*, steady-state READY/GRANT,
//             refresh path R_*)
//   cmd_t   : {cs_n, ras_n, cas_n, we_n} command encoding
//   CMD_*   : the five commands the sequencer ever issues
//   max_int : elaboration-time helper for counter sizing
package sdram_init_ref_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    I_WAIT,
    I_PRE,
    I_TRP,
    I_AR,
    I_TRFC,
    I_LMR,
    I_TMRD,
    READY,
    GRANT,
    R_PRE,
    R_TRP,
    R_AR,
    R_TRFC
  } state_t;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_INHIBIT = 4'b1111;
  localparam cmd_t CMD_NOP     = 4'b0111;
  localparam cmd_t CMD_PRE     = 4'b0010;
  localparam cmd_t CMD_AR      = 4'b0001;
  localparam cmd_t CMD_LMR     = 4'b0000;

  // Pending-refresh counter saturates here; a tick at this level is lost.
  localparam int PENDING_MAX = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_init_ref_seq_if.sv
// Command-bus / arbitration bundle between the sequencer and the access engine.
//   acc_req    : engine asks for the SDRAM command bus
//   acc_gnt    : bus granted to the engine
//   ref_urgent : refresh backlog is high, engine must release the bus
//   seq_*      : sequencer-driven SDRAM command/address pins
// modport master = sequencer side, modport slave = access-engine side.
interface sdram_init_ref_seq_if #(
  parameter int ADDR_W = 13,
  parameter int BA_W   = 2
);

  logic              acc_req;
  logic              acc_gnt;
  logic              ref_urgent;
  logic              seq_cs_n;
  logic              seq_ras_n;
  logic              seq_cas_n;
  logic              seq_we_n;
  logic [ADDR_W-1:0] seq_addr;
  logic [BA_W-1:0]   seq_ba;

  modport master (
    input  acc_req,
    output acc_gnt,
    output ref_urgent,
    output seq_cs_n,
    output seq_ras_n,
    output seq_cas_n,
    output seq_we_n,
    output seq_addr,
    output seq_ba
  );

  modport slave (
    output acc_req,
    input  acc_gnt,
    input  ref_urgent,
    input  seq_cs_n,
    input  seq_ras_n,
    input  seq_cas_n,
    input  seq_we_n,
    input  seq_addr,
    input  seq_ba
  );

endinterface

// File: rtl/sdram_init_ref_seq_ref_timer.sv
// Refresh interval timer and pending-refresh bookkeeping.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : high once init has completed; low clears timer and backlog
//   ar_issued    : an AUTO REFRESH is on the bus this cycle
//   pending      : refreshes owed (0..8, saturating)
//   ref_urgent   : pending >= REF_URGENT (combinational from the register)
//   ref_overflow : sticky, a tick arrived while pending was already 8
module sdram_ref_timer
  import sdram_init_ref_seq_pkg::*;
#(
  parameter int REF_INTERVAL = 1560,
  parameter int REF_URGENT   = 4,
  parameter int CNT_W        = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ar_issued,
  output logic [3:0] pending,
  output logic       ref_urgent,
  output logic       ref_overflow
);

  localparam logic [CNT_W-1:0] IVAL_LD  = CNT_W'(REF_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       PEND_MAX = 4'(PENDING_MAX);
  localparam logic [3:0]       URG_LVL  = 4'(REF_URGENT);

  logic [CNT_W-1:0] ival_cnt;
  logic             tick;

  // The interval counter is preloaded while disabled so the first tick lands
  // exactly REF_INTERVAL cycles after enable rises.
  assign tick = enable && (ival_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ival_cnt     <= IVAL_LD;
      pending      <= '0;
      ref_overflow <= 1'b0;
    end else if (!enable) begin
      ival_cnt <= IVAL_LD;
      pending  <= '0;
    end else begin
      ival_cnt <= tick ? IVAL_LD : (ival_cnt - CNT_ONE);
      // A tick coinciding with an AR cancels out.
      if (tick && !ar_issued && (pending != PEND_MAX)) begin
        pending <= pending + 4'd1;
      end else if (ar_issued && !tick && (pending != '0)) begin
        pending <= pending - 4'd1;
      end
      if (tick && (pending == PEND_MAX)) begin
        ref_overflow <= 1'b1;
      end
    end
  end

  assign ref_urgent = (pending >= URG_LVL);

endmodule

// File: rtl/sdram_init_ref_seq.sv
// SDRAM command sequencer: power-up init, periodic auto-refresh, and command
// bus arbitration with the access engine.
//   sdram_clk     : clock, all logic on rising edge
//   sdram_resetn  : asynchronous active-low reset
//   sdram_en      : level; high starts init, low aborts to IDLE
//   cfg_mode_reg  : mode-register value placed on the address bus for LMR
//   init_done     : init complete (held until reset or sdram_en low)
//   ref_overflow  : sticky refresh-backlog overflow, cleared by reset only
//   bus (master)  : acc_req/acc_gnt handshake, ref_urgent, seq_* pins
// Command/address outputs are registered from the next state, so the command
// on the pins always matches the state the FSM is currently in.
module sdram_init_ref_seq
  import sdram_init_ref_seq_pkg::*;
#(
  parameter int INIT_WAIT    = 10000,
  parameter int T_RP         = 3,
  parameter int T_RFC        = 7,
  parameter int T_MRD        = 2,
  parameter int NUM_INIT_AR  = 2,
  parameter int REF_INTERVAL = 1560,
  parameter int REF_URGENT   = 4,
  parameter int ADDR_W       = 13,
  parameter int BA_W         = 2
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_resetn,
  input  logic                  sdram_en,
  input  logic [ADDR_W-1:0]     cfg_mode_reg,
  output logic                  init_done,
  output logic                  ref_overflow,
  sdram_init_ref_seq_if.master  bus
);

  localparam int CNT_W = $clog2(max_int(INIT_WAIT, REF_INTERVAL)) + 1;
  localparam int AR_W  = $clog2(NUM_INIT_AR + 1);

  // Delay loads are "cycles remaining minus one"; the single-cycle command
  // state itself accounts for one cycle of each tRP/tRFC/tMRD window.
  localparam logic [CNT_W-1:0]  INIT_LD = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0]  TRP_LD  = CNT_W'((T_RP  > 1) ? T_RP  - 2 : 0);
  localparam logic [CNT_W-1:0]  TRFC_LD = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CNT_W-1:0]  TMRD_LD = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [AR_W-1:0]   AR_NUM  = AR_W'(NUM_INIT_AR);
  localparam logic [ADDR_W-1:0] A10     = ADDR_W'(1 << 10);

  state_t            state, state_d;
  logic [CNT_W-1:0]  dly, dly_d;
  logic [AR_W-1:0]   ar_cnt, ar_cnt_d;
  cmd_t              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              gnt_q, gnt_d;
  logic              done_q, done_d;

  logic [3:0]        pending;
  logic              ref_urgent;
  logic              timer_en;
  logic              ar_issued;

  assign timer_en  = sdram_en && done_q;
  assign ar_issued = (state == R_AR);

  sdram_ref_timer #(
    .REF_INTERVAL (REF_INTERVAL),
    .REF_URGENT   (REF_URGENT),
    .CNT_W        (CNT_W)
  ) u_ref_timer (
    .clk          (sdram_clk),
    .rst_n        (sdram_resetn),
    .enable       (timer_en),
    .ar_issued    (ar_issued),
    .pending      (pending),
    .ref_urgent   (ref_urgent),
    .ref_overflow (ref_overflow)
  );

  // Next-state logic
  always_comb begin
    state_d  = state;
    dly_d    = dly;
    ar_cnt_d = ar_cnt;
    if (!sdram_en) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_d = I_WAIT;
          dly_d   = INIT_LD;
        end
        I_WAIT: begin
          if (dly == '0) state_d = I_PRE;
          else           dly_d   = dly - CNT_ONE;
        end
        I_PRE: begin
          ar_cnt_d = '0;
          if (T_RP > 1) begin
            state_d = I_TRP;
            dly_d   = TRP_LD;
          end else begin
            state_d = I_AR;
          end
        end
        I_TRP: begin
          if (dly == '0) state_d = I_AR;
          else           dly_d   = dly - CNT_ONE;
        end
        I_AR: begin
          ar_cnt_d = ar_cnt + AR_W'(1);
          if (T_RFC > 1) begin
            state_d = I_TRFC;
            dly_d   = TRFC_LD;
          end else begin
            state_d = (ar_cnt_d == AR_NUM) ? I_LMR : I_AR;
          end
        end
        I_TRFC: begin
          if (dly == '0) state_d = (ar_cnt == AR_NUM) ? I_LMR : I_AR;
          else           dly_d   = dly - CNT_ONE;
        end
        I_LMR: begin
          if (T_MRD > 1) begin
            state_d = I_TMRD;
            dly_d   = TMRD_LD;
          end else begin
            state_d = READY;
          end
        end
        I_TMRD: begin
          if (dly == '0) state_d = READY;
          else           dly_d   = dly - CNT_ONE;
        end
        READY: begin
          // Refresh wins a tie with a bus request.
          if (pending != '0) state_d = R_PRE;
          else if (bus.acc_req) state_d = GRANT;
        end
        GRANT: begin
          if (!bus.acc_req) state_d = READY;
        end
        R_PRE: begin
          if (T_RP > 1) begin
            state_d = R_TRP;
            dly_d   = TRP_LD;
          end else begin
            state_d = R_AR;
          end
        end
        R_TRP: begin
          if (dly == '0) state_d = R_AR;
          else           dly_d   = dly - CNT_ONE;
        end
        R_AR: begin
          if (T_RFC > 1) begin
            state_d = R_TRFC;
            dly_d   = TRFC_LD;
          end else begin
            // pending has not yet dropped for this AR; a tick landing in the
            // same cycle is picked up later from READY with a fresh PRE.
            state_d = (pending > 4'd1) ? R_AR : READY;
          end
        end
        R_TRFC: begin
          if (dly == '0) state_d = (pending != '0) ? R_AR : READY;
          else           dly_d   = dly - CNT_ONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from the next state
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = '0;
    case (state_d)
      IDLE:         cmd_d = CMD_INHIBIT;
      I_PRE, R_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = A10;
      end
      I_AR, R_AR:   cmd_d = CMD_AR;
      I_LMR: begin
        cmd_d  = CMD_LMR;
        addr_d = cfg_mode_reg;
      end
      default:      cmd_d = CMD_NOP;
    endcase
    gnt_d  = (state_d == GRANT);
    done_d = state_d inside {READY, GRANT, R_PRE, R_TRP, R_AR, R_TRFC};
  end

  // State and registered outputs
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state  <= IDLE;
      dly    <= '0;
      ar_cnt <= '0;
      cmd_q  <= CMD_INHIBIT;
      addr_q <= '0;
      gnt_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      dly    <= dly_d;
      ar_cnt <= ar_cnt_d;
      cmd_q  <= cmd_d;
      addr_q <= addr_d;
      gnt_q  <= gnt_d;
      done_q <= done_d;
    end
  end

  assign bus.seq_cs_n   = cmd_q[3];
  assign bus.seq_ras_n  = cmd_q[2];
  assign bus.seq_cas_n  = cmd_q[1];
  assign bus.seq_we_n   = cmd_q[0];
  assign bus.seq_addr   = addr_q;
  assign bus.seq_ba     = {BA_W{1'b0}};
  assign bus.acc_gnt    = gnt_q;
  assign bus.ref_urgent = ref_urgent;
  assign init_done      = done_q;

endmodule

// File: tb/tb_sdram_init_ref_seq.sv
// Directed bench for sdram_init_ref_seq with default parameters
// (INIT_WAIT 10000, tRP 3, tRFC 7, tMRD 2, 2 init ARs, interval 1560).
// Cycle numbers in comments count from the first READY cycle = 1.
module tb_sdram_init_ref_seq;
  import sdram_init_ref_seq_pkg::*;

  logic        sdram_clk = 1'b0;
  logic        sdram_resetn;
  logic        sdram_en;
  logic [12:0] cfg_mode_reg;
  logic        init_done;
  logic        ref_overflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        en;
    logic        req;
    logic [3:0]  cmd;
    logic [12:0] addr;
    logic        gnt;
    logic        done;
  } vec_t;

  vec_t tail_vec [19];

  sdram_init_ref_seq_if #(.ADDR_W(13), .BA_W(2)) bus ();

  sdram_init_ref_seq dut (
    .sdram_clk    (sdram_clk),
    .sdram_resetn (sdram_resetn),
    .sdram_en     (sdram_en),
    .cfg_mode_reg (cfg_mode_reg),
    .init_done    (init_done),
    .ref_overflow (ref_overflow),
    .bus          (bus)
  );

  always #5 sdram_clk = ~sdram_clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] cur_cmd();
    return {bus.seq_cs_n, bus.seq_ras_n, bus.seq_cas_n, bus.seq_we_n};
  endfunction

  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_cmd_after(input int n, input logic [3:0] exp, input string name);
    repeat (n) step();
    check(name, {28'd0, cur_cmd()}, {28'd0, exp});
  endtask

  // Raise sdram_en from IDLE and measure the NOP run up to the first PRE.
  task automatic run_wait(input string tag);
    int n;
    sdram_en = 1'b1;
    step();
    n = 0;
    while (cur_cmd() == CMD_NOP && n < 10100) begin
      n++;
      step();
    end
    check({tag, ".nop_count"}, n, 10000);
    check({tag, ".pre_cmd"}, {28'd0, cur_cmd()}, {28'd0, CMD_PRE});
    check({tag, ".pre_a10"}, {19'd0, bus.seq_addr}, 32'h400);
    check({tag, ".pre_done"}, {31'd0, init_done}, 0);
  endtask

  // Cycle-by-cycle checks from the cycle after the init PRE to first READY.
  task automatic run_tail(input string tag);
    for (int i = 0; i < 19; i++) begin
      sdram_en    = tail_vec[i].en;
      bus.acc_req = tail_vec[i].req;
      step();
      check($sformatf("%s.tail[%0d].cmd", tag, i), {28'd0, cur_cmd()}, {28'd0, tail_vec[i].cmd});
      check($sformatf("%s.tail[%0d].addr", tag, i), {19'd0, bus.seq_addr}, {19'd0, tail_vec[i].addr});
      check($sformatf("%s.tail[%0d].ba", tag, i), {30'd0, bus.seq_ba}, 0);
      check($sformatf("%s.tail[%0d].gnt", tag, i), {31'd0, bus.acc_gnt}, {31'd0, tail_vec[i].gnt});
      check($sformatf("%s.tail[%0d].done", tag, i), {31'd0, init_done}, {31'd0, tail_vec[i].done});
    end
  endtask

  initial begin
    int n;
    int ars;
    int pres;
    logic gnt_seen;

    // After PRE: 2 NOP, AR, 6 NOP, AR, 6 NOP, LMR, 1 NOP, READY (NOP, done=1)
    for (int i = 0; i < 19; i++) begin
      tail_vec[i] = '{en: 1'b1, req: 1'b0, cmd: CMD_NOP, addr: 13'h000, gnt: 1'b0, done: 1'b0};
    end
    tail_vec[2].cmd   = CMD_AR;
    tail_vec[9].cmd   = CMD_AR;
    tail_vec[16].cmd  = CMD_LMR;
    tail_vec[16].addr = 13'h033;
    tail_vec[18].done = 1'b1;

    sdram_resetn = 1'b0;
    sdram_en     = 1'b0;
    bus.acc_req  = 1'b0;
    cfg_mode_reg = 13'h033;
    repeat (3) step();

    check("rst.cmd", {28'd0, cur_cmd()}, {28'd0, CMD_INHIBIT});
    check("rst.addr", {19'd0, bus.seq_addr}, 0);
    check("rst.ba", {30'd0, bus.seq_ba}, 0);
    check("rst.gnt", {31'd0, bus.acc_gnt}, 0);
    check("rst.done", {31'd0, init_done}, 0);
    check("rst.urgent", {31'd0, bus.ref_urgent}, 0);
    check("rst.ovf", {31'd0, ref_overflow}, 0);

    sdram_resetn = 1'b1;
    repeat (2) step();
    check("idle.cmd", {28'd0, cur_cmd()}, {28'd0, CMD_INHIBIT});

    // Power-up init
    run_wait("init1");
    run_tail("init1");

    // Idle refresh: tick at 1560, pending seen at 1561, PRE at 1562, AR at 1565
    gnt_seen = 1'b0;
    n = 0;
    do begin
      step();
      n++;
      gnt_seen |= bus.acc_gnt;
    end while (cur_cmd() != CMD_PRE && n < 2000);
    check("ref1.pre_delay", n, 1561);
    check("ref1.pre_a10", {19'd0, bus.seq_addr}, 32'h400);
    expect_cmd_after(3, CMD_AR, "ref1.ar");
    n = 0;
    do begin
      step();
      n++;
      gnt_seen |= bus.acc_gnt;
    end while (cur_cmd() != CMD_AR && n < 2000);
    check("ref2.ar_period", n, 1560);
    check("ref.gnt_idle", {31'd0, gnt_seen}, 0);

    // Request during the refresh window (cycle 3125): must wait for READY
    bus.acc_req = 1'b1;
    gnt_seen = 1'b0;
    repeat (7) begin
      step();
      gnt_seen |= bus.acc_gnt;
    end
    check("req.no_preempt_ref", {31'd0, gnt_seen}, 0);
    check("req.ready_cmd", {28'd0, cur_cmd()}, {28'd0, CMD_NOP});
    step();
    check("req.gnt", {31'd0, bus.acc_gnt}, 1);
    check("req.urgent0", {31'd0, bus.ref_urgent}, 0);

    // Held grant: 4th pending tick at 9360 -> urgent visible at 9361
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.ref_urgent && n < 7000);
    check("urg.delay", n, 6228);
    check("urg.gnt_held", {31'd0, bus.acc_gnt}, 1);

    // Drop request: gnt low next cycle, then PRE and 4 ARs spaced by tRFC
    bus.acc_req = 1'b0;
    step();
    check("urg.gnt_drop", {31'd0, bus.acc_gnt}, 0);
    step();
    check("urg.pre", {28'd0, cur_cmd()}, {28'd0, CMD_PRE});
    expect_cmd_after(3, CMD_AR, "urg.ar0");
    step();
    check("urg.urgent_clear", {31'd0, bus.ref_urgent}, 0);
    expect_cmd_after(6, CMD_AR, "urg.ar1");
    expect_cmd_after(7, CMD_AR, "urg.ar2");
    expect_cmd_after(7, CMD_AR, "urg.ar3");
    expect_cmd_after(7, CMD_NOP, "urg.no_ar4");

    // Overflow: hold grant from 9394; 9th tick at 23400 -> sticky at 23401
    bus.acc_req = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!ref_overflow && n < 16000);
    check("ovf.delay", n, 14007);
    check("ovf.urgent", {31'd0, bus.ref_urgent}, 1);
    check("ovf.gnt", {31'd0, bus.acc_gnt}, 1);
    bus.acc_req = 1'b0;
    step();
    check("ovf.gnt_drop", {31'd0, bus.acc_gnt}, 0);
    ars = 0;
    pres = 0;
    repeat (80) begin
      step();
      if (cur_cmd() == CMD_AR) ars++;
      if (cur_cmd() == CMD_PRE) pres++;
    end
    check("ovf.drain_ars", ars, 8);
    check("ovf.drain_pres", pres, 1);
    check("ovf.sticky", {31'd0, ref_overflow}, 1);
    check("ovf.urgent_clear", {31'd0, bus.ref_urgent}, 0);

    // sdram_en low from READY
    sdram_en = 1'b0;
    step();
    check("dis.cmd", {28'd0, cur_cmd()}, {28'd0, CMD_INHIBIT});
    check("dis.done", {31'd0, init_done}, 0);
    check("dis.ovf_kept", {31'd0, ref_overflow}, 1);

    // Re-enable, abort inside the init tRFC window
    run_wait("init2");
    expect_cmd_after(3, CMD_AR, "init2.ar");
    step();
    sdram_en = 1'b0;
    step();
    check("trfc_abort.cmd", {28'd0, cur_cmd()}, {28'd0, CMD_INHIBIT});
    check("trfc_abort.done", {31'd0, init_done}, 0);
    check("trfc_abort.gnt", {31'd0, bus.acc_gnt}, 0);

    // Full init again, then reset while granted
    run_wait("init3");
    run_tail("init3");
    bus.acc_req = 1'b1;
    step();
    check("grant2.gnt", {31'd0, bus.acc_gnt}, 1);
    #2;
    sdram_resetn = 1'b0;
    #1;
    check("async_rst.cmd", {28'd0, cur_cmd()}, {28'd0, CMD_INHIBIT});
    check("async_rst.gnt", {31'd0, bus.acc_gnt}, 0);
    check("async_rst.done", {31'd0, init_done}, 0);
    check("async_rst.ovf", {31'd0, ref_overflow}, 0);
    bus.acc_req = 1'b0;
    sdram_en    = 1'b0;
    step();
    sdram_resetn = 1'b1;
    run_wait("init4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
